// File: rtl/stopwatch_tick_gen.sv
// Stopwatch control: button conditioning, IDLE/RUN/PAUSE FSM and tick prescaler.
// Optional debounce is compiled in with `define STOPWATCH_TICK_GEN_DEBOUNCE_EN.
module stopwatch_tick_gen #(
  parameter int unsigned DIVIDER         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start_stop_btn,
  input  logic clear_btn,
  output logic tick,
  output logic running,
  output logic clear_pulse
);

  localparam int unsigned PRESC_W = 16;
  localparam int unsigned NUM_BTN = 2;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIVIDER - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Reject out-of-range parameters at elaboration
  if (DIVIDER < 1 || DIVIDER > 65535) begin : g_bad_divider
    $error("stopwatch_tick_gen: DIVIDER must be 1..65535");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("stopwatch_tick_gen: DEBOUNCE_CYCLES must be 1..65535");
  end

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] sync_q1;
  logic [NUM_BTN-1:0] sync_q2;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] prev;
  logic [NUM_BTN-1:0] press;

  // Bit 0 is start/stop, bit 1 is clear
  assign raw = {clear_btn, start_stop_btn};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

`ifdef STOPWATCH_TICK_GEN_DEBOUNCE_EN
  localparam int unsigned DB_W = 16;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt [NUM_BTN];

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_q2[i] != level[i]) begin
          if (db_cnt[i] >= DB_LAST) begin
            level[i]  <= sync_q2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign level = sync_q2;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= level;
  end

  assign press = level & ~prev;

  state_t               state;
  state_t               state_next;
  logic [PRESC_W-1:0]   presc;
  logic [PRESC_W-1:0]   presc_next;
  logic                 tick_next;
  logic                 running_next;
  logic                 clear_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      presc       <= '0;
      tick        <= 1'b0;
      running     <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      presc       <= presc_next;
      tick        <= tick_next;
      running     <= running_next;
      clear_pulse <= clear_next;
    end
  end

  // Clear outranks start/stop except in RUN, where clear is dropped
  always_comb begin
    state_next = state;
    presc_next = presc;
    tick_next  = 1'b0;
    clear_next = 1'b0;
    case (state)
      S_IDLE: begin
        presc_next = '0;
        if (press[1]) begin
          clear_next = 1'b1;
        end else if (press[0]) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (press[0]) begin
          state_next = S_PAUSE;
        end else if (presc >= PRESC_MAX) begin
          presc_next = '0;
          tick_next  = 1'b1;
        end else begin
          presc_next = presc + PRESC_W'(1);
        end
      end
      S_PAUSE: begin
        if (press[1]) begin
          state_next = S_IDLE;
          presc_next = '0;
          clear_next = 1'b1;
        end else if (press[0]) begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_IDLE;
        presc_next = '0;
      end
    endcase
    running_next = (state_next == S_RUN);
  end

endmodule

// File: tb/tb_stopwatch_tick_gen.sv
// Directed bench for stopwatch_tick_gen (DIVIDER=4). Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
module tb_stopwatch_tick_gen;

  logic clk = 1'b0;
  logic rst;
  logic start_stop_btn;
  logic clear_btn;
  logic tick;
  logic running;
  logic clear_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_tick_gen #(
    .DIVIDER        (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_stop_btn(start_stop_btn),
    .clear_btn     (clear_btn),
    .tick          (tick),
    .running       (running),
    .clear_pulse   (clear_pulse)
  );

  task automatic test_reset();
    rst = 1'b1;
    start_stop_btn = 1'b0;
    clear_btn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", running); end
    total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL reset_clear_pulse: got %b want 0", clear_pulse); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL idle_no_tick cycle %0d: got %b want 0", i, tick); end
    end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL idle_running: got %b want 0", running); end
  endtask

  task automatic test_start_spacing();
    int nticks;
    logic exp;
    nticks = 0;
    start_stop_btn = 1'b1;
    @(negedge clk);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL start_early1: got %b want 0", running); end
    @(negedge clk);
    start_stop_btn = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL start_early2: got %b want 0", running); end
    @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running: got %b want 1", running); end
    // j counts RUN edges since entry; a tick follows every 4th
    for (int j = 0; j <= 48; j++) begin
      if (j > 0) @(negedge clk);
      exp = (j > 0) && (j % 4 == 0);
      total++; if (tick !== exp) begin bad++; $display("FAIL tick_spacing j=%0d: got %b want %b", j, tick, exp); end
      if (tick === 1'b1) nticks++;
    end
    total++; if (nticks != 12) begin bad++; $display("FAIL tick_count: got %0d want 12", nticks); end
  endtask

  task automatic test_pause_resume();
    logic exp;
    // presc is 0 here; the press acts on the edge where presc is 2
    start_stop_btn = 1'b1;
    @(negedge clk);
    start_stop_btn = 1'b0;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL pause_pre_tick: got %b want 0", tick); end
    @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL pause_pre_running: got %b want 1", running); end
    @(negedge clk);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running: got %b want 0", running); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL pause_tick: got %b want 0", tick); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL paused_tick i=%0d: got %b want 0", i, tick); end
      total++; if (running !== 1'b0) begin bad++; $display("FAIL paused_running i=%0d: got %b want 0", i, running); end
    end
    start_stop_btn = 1'b1;
    @(negedge clk);
    start_stop_btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL resume_running: got %b want 1", running); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL resume_tick0: got %b want 0", tick); end
    // Resumed at presc=2: tick after 2 RUN edges, then every 4
    for (int k = 4; k <= 9; k++) begin
      @(negedge clk);
      exp = (k == 5) || (k == 9);
      total++; if (tick !== exp) begin bad++; $display("FAIL resume_tick k=%0d: got %b want %b", k, tick, exp); end
    end
  endtask

  task automatic test_clear();
    logic exp;
    // Clear while running is dropped
    clear_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) clear_btn = 1'b0;
      exp = (k % 4 == 0);
      total++; if (tick !== exp) begin bad++; $display("FAIL run_clear_tick k=%0d: got %b want %b", k, tick, exp); end
      total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL run_clear_pulse k=%0d: got %b want 0", k, clear_pulse); end
    end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL run_clear_running: got %b want 1", running); end
    // Pause on the edge where presc==3 would wrap: no tick
    @(negedge clk);
    start_stop_btn = 1'b1;
    @(negedge clk);
    start_stop_btn = 1'b0;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL wrap_pause_t1: got %b want 0", tick); end
    @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL wrap_pause_running1: got %b want 1", running); end
    @(negedge clk);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL wrap_pause_running: got %b want 0", running); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL wrap_pause_tick: got %b want 0", tick); end
    @(negedge clk);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL wrap_pause_after: got %b want 0", tick); end
    // Clear in PAUSE
    clear_btn = 1'b1;
    @(negedge clk);
    clear_btn = 1'b0;
    total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL pause_clear_early1: got %b want 0", clear_pulse); end
    @(negedge clk);
    total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL pause_clear_early2: got %b want 0", clear_pulse); end
    @(negedge clk);
    total++; if (clear_pulse !== 1'b1) begin bad++; $display("FAIL pause_clear_pulse: got %b want 1", clear_pulse); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_clear_running: got %b want 0", running); end
    @(negedge clk);
    total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL pause_clear_width: got %b want 0", clear_pulse); end
    // presc must restart at 0: first tick after 4 RUN edges
    start_stop_btn = 1'b1;
    @(negedge clk);
    start_stop_btn = 1'b0;
    @(negedge clk);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL restart_early: got %b want 0", running); end
    @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL restart_running: got %b want 1", running); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp = (k == 4);
      total++; if (tick !== exp) begin bad++; $display("FAIL restart_tick k=%0d: got %b want %b", k, tick, exp); end
    end
    // Back to PAUSE, then both buttons together
    start_stop_btn = 1'b1;
    @(negedge clk);
    start_stop_btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL both_setup_pause: got %b want 0", running); end
    start_stop_btn = 1'b1;
    clear_btn = 1'b1;
    @(negedge clk);
    start_stop_btn = 1'b0;
    clear_btn = 1'b0;
    @(negedge clk);
    total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL both_early: got %b want 0", clear_pulse); end
    @(negedge clk);
    total++; if (clear_pulse !== 1'b1) begin bad++; $display("FAIL both_clear_pulse: got %b want 1", clear_pulse); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL both_running: got %b want 0", running); end
    @(negedge clk);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL both_running_after: got %b want 0", running); end
    total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL both_width: got %b want 0", clear_pulse); end
    // Clear in IDLE pulses and stays IDLE
    clear_btn = 1'b1;
    @(negedge clk);
    clear_btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (clear_pulse !== 1'b1) begin bad++; $display("FAIL idle_clear_pulse: got %b want 1", clear_pulse); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL idle_clear_running: got %b want 0", running); end
    @(negedge clk);
    total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL idle_clear_width: got %b want 0", clear_pulse); end
  endtask

  task automatic test_held();
    int rises;
    logic prev_run;
    rises = 0;
    prev_run = running;
    start_stop_btn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 2) begin
        total++; if (running !== 1'b0) begin bad++; $display("FAIL held_early: got %b want 0", running); end
      end
      if (i == 3) begin
        total++; if (running !== 1'b1) begin bad++; $display("FAIL held_enter: got %b want 1", running); end
      end
      if (running === 1'b1 && prev_run !== 1'b1) rises++;
      prev_run = running;
    end
    start_stop_btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (running === 1'b1 && prev_run !== 1'b1) rises++;
      prev_run = running;
    end
    total++; if (rises != 1) begin bad++; $display("FAIL held_rises: got %0d want 1", rises); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL held_final: got %b want 1", running); end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL rerun_reset: got %b want 0", running); end
    start_stop_btn = 1'b1;
    @(negedge clk);
    start_stop_btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL rerun_running: got %b want 1", running); end
    repeat (3) @(negedge clk);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL rerun_presc3_tick: got %b want 0", tick); end
    // The next edge would wrap, but reset wins
    rst = 1'b1;
    @(negedge clk);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL midrun_reset_tick: got %b want 0", tick); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL midrun_reset_running: got %b want 0", running); end
    total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL midrun_reset_clear: got %b want 0", clear_pulse); end
    // Button held across reset release counts as one press
    start_stop_btn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL held_rst_r8: got %b want 0", running); end
    @(negedge clk);
    @(negedge clk);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL held_rst_early: got %b want 0", running); end
    @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL held_rst_enter: got %b want 1", running); end
    start_stop_btn = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL held_rst_stay: got %b want 1", running); end
  endtask

`ifdef STOPWATCH_TICK_GEN_DEBOUNCE_EN
  task automatic test_debounce();
    start_stop_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start_stop_btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      total++; if (running !== 1'b0) begin bad++; $display("FAIL glitch_running i=%0d: got %b want 0", i, running); end
    end
    start_stop_btn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) begin
        start_stop_btn = 1'b0;
        total++; if (running !== 1'b0) begin bad++; $display("FAIL db_press_early: got %b want 0", running); end
      end
      if (k == 6) begin
        total++; if (running !== 1'b1) begin bad++; $display("FAIL db_press_enter: got %b want 1", running); end
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start_stop_btn = 1'b0;
    clear_btn = 1'b0;
    test_reset();
`ifdef STOPWATCH_TICK_GEN_DEBOUNCE_EN
    test_debounce();
`else
    test_start_spacing();
    test_pause_resume();
    test_clear();
    test_held();
    test_reset_mid_run();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
